countdown_timer_core: RTL and testbench

- Down-counting kitchen timer core. It is the countdown counterpart to the team's up-counting stopwatch.
- The user presets minutes and seconds with button pulses, starts the timer, and it counts down to 00:00, then raises an alarm.
- Sits between the button debounce/edge-detect front end and FND_4digit_cntr. Drives the 16-bit BCD display value and the LED/buzzer outputs.

---
 rtl/countdown_timer_core.sv | 176 +++++++++++++++++
 tb/tb_countdown_timer_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_core.sv
// Down-counting MM:SS kitchen timer: button presets, 1 s countdown with BCD borrow,
// then a timed alarm with a half-second buzzer cadence before falling back to idle.
module countdown_timer_core #(
  parameter int TICKS_PER_SEC = 125_000_000,
  parameter int ALARM_SECS    = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_inc_sec,
  input  logic        btn_inc_min,
  output logic [15:0] value,
  output logic        running,
  output logic        alarm,
  output logic        buzzer
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] HALF_SEC   = PW'(TICKS_PER_SEC / 2);
  localparam logic [AW-1:0] ALARM_DONE = AW'(ALARM_SECS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t        state, next_state;
  logic [15:0]   next_value;
  logic [PW-1:0] prescaler, next_prescaler;
  logic [AW-1:0] alarm_cnt, next_alarm_cnt;
  logic          tick;
  logic [15:0]   dec_value;

  // Seconds field wraps 59 -> 00 without touching the minutes.
  function automatic logic [7:0] inc_sec_bcd(input logic [7:0] s);
    logic [3:0] hi, lo;
    {hi, lo} = s;
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd5) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  function automatic logic [7:0] inc_min_bcd(input logic [7:0] m);
    logic [3:0] hi, lo;
    {hi, lo} = m;
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Only called with a non-zero value, so the min10 borrow never underflows.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign tick      = (prescaler == TICK_LAST);
  assign dec_value = dec_bcd(value);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_state     = state;
    next_value     = value;
    next_prescaler = prescaler;
    next_alarm_cnt = alarm_cnt;

    unique case (state)
      IDLE: begin
        next_prescaler = '0;
        next_alarm_cnt = '0;
        if (btn_clear) begin
          next_value = 16'h0000;
        end else if (btn_start) begin
          if (value != 16'h0000) next_state = RUN;
        end else begin
          if (btn_inc_sec) next_value[7:0]  = inc_sec_bcd(value[7:0]);
          if (btn_inc_min) next_value[15:8] = inc_min_bcd(value[15:8]);
        end
      end

      RUN: begin
        if (btn_clear) begin
          next_state     = IDLE;
          next_value     = 16'h0000;
          next_prescaler = '0;
        end else if (btn_start) begin
          next_state = PAUSE;
        end else if (tick) begin
          next_prescaler = '0;
          next_value     = dec_value;
          if (dec_value == 16'h0000) begin
            next_state     = ALARM;
            next_alarm_cnt = '0;
          end
        end else begin
          next_prescaler = prescaler + 1'b1;
        end
      end

      PAUSE: begin
        if (btn_clear) begin
          next_state     = IDLE;
          next_value     = 16'h0000;
          next_prescaler = '0;
        end else if (btn_start) begin
          next_state     = RUN;
          next_prescaler = '0;
        end
      end

      ALARM: begin
        next_value = 16'h0000;
        if (btn_clear || btn_start) begin
          next_state     = IDLE;
          next_prescaler = '0;
        end else if (tick) begin
          next_prescaler = '0;
          next_alarm_cnt = alarm_cnt + 1'b1;
          if (alarm_cnt + 1'b1 == ALARM_DONE) next_state = IDLE;
        end else begin
          next_prescaler = prescaler + 1'b1;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // NOTE: every register here has a defined reset value; the display and flags must read 0 the instant reset_n drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      value     <= 16'h0000;
      prescaler <= '0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= next_state;
      value     <= next_value;
      prescaler <= next_prescaler;
      alarm_cnt <= next_alarm_cnt;
      running   <= (next_state == RUN);
      alarm     <= (next_state == ALARM);
    end
  end

  assign buzzer = (state == ALARM) && (prescaler < HALF_SEC);

endmodule

// File: tb/tb_countdown_timer_core.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// button stream, all compared every cycle against a seconds/minutes arithmetic model.
module tb_countdown_timer_core;

  localparam int T = 4;
  localparam int A = 2;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_CLEAR = 4'b0100;
  localparam logic [3:0] B_SEC   = 4'b0010;
  localparam logic [3:0] B_MIN   = 4'b0001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        btn_start = 1'b0, btn_clear = 1'b0, btn_inc_sec = 1'b0, btn_inc_min = 1'b0;
  logic [15:0] value;
  logic        running, alarm, buzzer;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  countdown_timer_core #(.TICKS_PER_SEC(T), .ALARM_SECS(A)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .btn_inc_sec (btn_inc_sec),
    .btn_inc_min (btn_inc_min),
    .value       (value),
    .running     (running),
    .alarm       (alarm),
    .buzzer      (buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: minutes and seconds as integers, time kept as cycles elapsed in the current second.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_min = 0, m_sec = 0, m_cnt = 0, m_asec = 0;

  function automatic logic [15:0] bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int t;
    if (!reset_n) begin
      m_mode <= M_IDLE; m_min <= 0; m_sec <= 0; m_cnt <= 0; m_asec <= 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_cnt <= 0;
          if (btn_clear) begin
            m_min <= 0; m_sec <= 0;
          end else if (btn_start) begin
            if (m_min != 0 || m_sec != 0) m_mode <= M_RUN;
          end else begin
            if (btn_inc_sec) m_sec <= (m_sec + 1) % 60;
            if (btn_inc_min) m_min <= (m_min + 1) % 100;
          end
        end
        M_RUN: begin
          if (btn_clear) begin
            m_mode <= M_IDLE; m_min <= 0; m_sec <= 0;
          end else if (btn_start) begin
            m_mode <= M_PAUSE;
          end else if (m_cnt + 1 == T) begin
            t = m_min * 60 + m_sec - 1;
            m_min <= t / 60;
            m_sec <= t % 60;
            m_cnt <= 0;
            if (t == 0) begin
              m_mode <= M_ALARM; m_asec <= 0;
            end
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        M_PAUSE: begin
          if (btn_clear) begin
            m_mode <= M_IDLE; m_min <= 0; m_sec <= 0;
          end else if (btn_start) begin
            m_mode <= M_RUN; m_cnt <= 0;
          end
        end
        M_ALARM: begin
          if (btn_clear || btn_start) begin
            m_mode <= M_IDLE;
          end else if (m_cnt + 1 == T) begin
            m_cnt <= 0;
            if (m_asec + 1 == A) m_mode <= M_IDLE;
            else m_asec <= m_asec + 1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model value", value, bcd(m_min, m_sec));
      check("model running", 16'(running), 16'(m_mode == M_RUN));
      check("model alarm", 16'(alarm), 16'(m_mode == M_ALARM));
      check("model buzzer", 16'(buzzer), 16'(m_mode == M_ALARM && m_cnt < T / 2));
    end
  end

  task automatic drive(input logic [3:0] b);
    @(negedge clk);
    {btn_start, btn_clear, btn_inc_sec, btn_inc_min} = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(B_NONE);
  endtask

  task automatic preset(input int m, input int s);
    drive(B_CLEAR);
    for (int i = 0; i < m; i++) drive(B_MIN);
    for (int i = 0; i < s; i++) drive(B_SEC);
    drive(B_NONE);
  endtask

  function automatic logic [3:0] rand_btn();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70)      return B_NONE;
    else if (r < 80) return B_SEC;
    else if (r < 85) return B_MIN;
    else if (r < 87) return B_SEC | B_MIN;
    else if (r < 93) return B_START;
    else if (r < 96) return B_CLEAR;
    else if (r < 98) return B_CLEAR | B_START;
    else             return B_CLEAR | B_SEC;
  endfunction

  logic [15:0] buzz_pat;

  initial begin
    #2 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("reset value", value, 16'h0000);
    check("reset running", 16'(running), 16'h0);
    check("reset alarm", 16'(alarm), 16'h0);
    check("reset buzzer", 16'(buzzer), 16'h0);
    idle(2);
    #1 reset_n = 1'b1;

    // Preset wrap-around and simultaneous increments
    for (int i = 0; i < 59; i++) drive(B_SEC);
    drive(B_NONE);
    check("sec 59", value, 16'h0059);
    drive(B_SEC); drive(B_NONE);
    check("sec wrap", value, 16'h0000);
    for (int i = 0; i < 99; i++) drive(B_MIN);
    drive(B_NONE);
    check("min 99", value, 16'h9900);
    drive(B_MIN); drive(B_NONE);
    check("min wrap", value, 16'h0000);
    drive(B_MIN);
    for (int i = 0; i < 5; i++) drive(B_SEC);
    drive(B_NONE);
    check("preset 0105", value, 16'h0105);
    drive(B_SEC | B_MIN); drive(B_NONE);
    check("both inc", value, 16'h0206);

    // Countdown with minute borrow all the way to the alarm
    preset(1, 0);
    drive(B_START); drive(B_NONE);
    check("run start", 16'(running), 16'h1);
    check("run hold", value, 16'h0100);
    idle(4);
    check("borrow 0059", value, 16'h0059);
    idle(4);
    check("dec 0058", value, 16'h0058);
    idle(231);
    check("last sec", value, 16'h0001);
    check("no alarm yet", 16'(alarm), 16'h0);
    idle(1);
    check("reach zero", value, 16'h0000);
    check("alarm on zero", 16'(alarm), 16'h1);
    idle(10);

    // Pause holds value, resume restarts a full second
    preset(0, 3);
    drive(B_START); drive(B_NONE);
    idle(4);
    check("pause pre", value, 16'h0002);
    drive(B_START); drive(B_NONE);
    check("paused run", 16'(running), 16'h0);
    idle(49);
    check("paused hold", value, 16'h0002);
    drive(B_START); drive(B_NONE);
    idle(3);
    check("resume early", value, 16'h0002);
    check("resume run", 16'(running), 16'h1);
    idle(1);
    check("resume dec", value, 16'h0001);
    idle(20);

    // Alarm buzzer cadence and auto return to idle
    preset(0, 1);
    drive(B_START); drive(B_NONE);
    idle(3);
    check("pre alarm", 16'(alarm), 16'h0);
    buzz_pat = 16'b1100;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("alarm high", 16'(alarm), 16'h1);
      check("buzzer pattern", 16'(buzzer), 16'(buzz_pat[3-i]));
    end
    idle(4);
    check("alarm last", 16'(alarm), 16'h1);
    idle(1);
    check("alarm auto off", 16'(alarm), 16'h0);

    // Start during alarm returns to idle on the next cycle
    preset(0, 1);
    drive(B_START); drive(B_NONE);
    idle(4);
    check("alarm again", 16'(alarm), 16'h1);
    drive(B_START); drive(B_NONE);
    check("alarm stop", 16'(alarm), 16'h0);
    check("alarm stop run", 16'(running), 16'h0);

    // Clear beats start; start on zero is ignored
    preset(0, 5);
    drive(B_START); drive(B_NONE);
    idle(2);
    drive(B_START | B_CLEAR); drive(B_NONE);
    check("clr>start value", value, 16'h0000);
    check("clr>start run", 16'(running), 16'h0);
    drive(B_START); drive(B_NONE);
    check("start on zero", 16'(running), 16'h0);

    // Asynchronous reset between clock edges
    preset(1, 23);
    drive(B_START); drive(B_NONE);
    check("pre reset value", value, 16'h0123);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async value", value, 16'h0000);
    check("async running", 16'(running), 16'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Random button stream against the model
    for (int i = 0; i < 3000; i++) drive(rand_btn());
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
